// File: rtl/lookahead_subtractor_pipe.sv
// ============================================================================
// Module      : lookahead_subtractor_pipe
// Description : Two-stage pipelined 16-bit subtractor, D = A - B - bin, with
//               borrow-out. Computed as A + ~B + ~bin through 4-bit group
//               propagate/generate lookahead. The low half resolves in stage 1
//               and the high half in stage 2. Valid/ready on both sides.
//               Optional macro SUB_FLAGS_EN adds V/Z/N flag outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lookahead_subtractor_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             bout
`ifdef SUB_FLAGS_EN
    ,
    output logic             V,
    output logic             Z,
    output logic             N
`endif
);

    localparam int c_HALF = WIDTH / 2;
    localparam int c_NGRP = c_HALF / GROUP;

    // Adds one half-width slice (a + bn + cin) using group lookahead.
    // Group carries come from the group Pg/Gg terms; bit carries inside a
    // group are expanded from that group's carry-in. Returns {cout, sum}.
    function automatic logic [c_HALF:0] f_half_sum(
        input logic [c_HALF-1:0] a,
        input logic [c_HALF-1:0] bn,
        input logic              cin
    );
        logic [c_HALF-1:0] p;
        logic [c_HALF-1:0] g;
        logic [c_HALF-1:0] c;
        logic              gg;
        logic              pg;
        logic              cg;
        p  = a ^ bn;
        g  = a & bn;
        c  = '0;
        cg = cin;
        for (int k = 0; k < c_NGRP; k++) begin
            c[k*GROUP] = cg;
            for (int j = 1; j < GROUP; j++) begin
                c[k*GROUP+j] = g[k*GROUP+j-1] | (p[k*GROUP+j-1] & c[k*GROUP+j-1]);
            end
            gg = 1'b0;
            pg = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                gg = g[k*GROUP+j] | (p[k*GROUP+j] & gg);
                pg = pg & p[k*GROUP+j];
            end
            cg = gg | (pg & cg);
        end
        return {cg, p ^ c};
    endfunction

    // Stage 1 registers
    logic              r_s1_valid;
    logic [c_HALF-1:0] r_s1_dlo;
    logic              r_s1_c8;
    logic [c_HALF-1:0] r_s1_ahi;
    logic [c_HALF-1:0] r_s1_bnhi;

    // Stage 2 (output) registers
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_d;
    logic              r_bout;

    // Combinational datapath and handshake
    logic [WIDTH-1:0]  w_bn;
    logic [c_HALF:0]   w_lo;
    logic [c_HALF:0]   w_hi;
    logic [WIDTH-1:0]  w_d_full;
    logic              w_s2_adv;
    logic              w_accept;

    assign w_bn     = ~B;
    assign w_lo     = f_half_sum(A[c_HALF-1:0], w_bn[c_HALF-1:0], ~bin);
    assign w_hi     = f_half_sum(r_s1_ahi, r_s1_bnhi, r_s1_c8);
    assign w_d_full = {w_hi[c_HALF-1:0], r_s1_dlo};

    // Stage 2 moves when stage 1 holds data and the output slot is free or
    // being drained this cycle; in_ready never depends on in_valid.
    assign w_s2_adv = r_s1_valid & (~r_out_valid | out_ready);
    assign in_ready = ~r_s1_valid | w_s2_adv;
    assign w_accept = in_valid & in_ready;

    // Stage 1: capture low-half result, carry into bit 8 and upper operands
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1_valid <= 1'b0;
            r_s1_dlo   <= '0;
            r_s1_c8    <= 1'b0;
            r_s1_ahi   <= '0;
            r_s1_bnhi  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_dlo   <= w_lo[c_HALF-1:0];
            r_s1_c8    <= w_lo[c_HALF];
            r_s1_ahi   <= A[WIDTH-1:c_HALF];
            r_s1_bnhi  <= w_bn[WIDTH-1:c_HALF];
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: finish upper half and register the full result; hold on stall
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_out_valid <= 1'b0;
            r_d         <= '0;
            r_bout      <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= 1'b1;
            r_d         <= w_d_full;
            r_bout      <= ~w_hi[c_HALF];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign D         = r_d;
    assign bout      = r_bout;

`ifdef SUB_FLAGS_EN
    // A[15] and B[15] travel through stage 1 inside the upper operand slices
    logic r_v;
    logic r_z;
    logic r_n;
    logic w_a_msb;
    logic w_b_msb;
    logic w_v;

    assign w_a_msb = r_s1_ahi[c_HALF-1];
    assign w_b_msb = ~r_s1_bnhi[c_HALF-1];
    assign w_v     = (w_a_msb ^ w_b_msb) & (w_a_msb ^ w_d_full[WIDTH-1]);

    // Flags register alongside D with identical advance/hold/reset behaviour
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_v <= 1'b0;
            r_z <= 1'b0;
            r_n <= 1'b0;
        end else if (w_s2_adv) begin
            r_v <= w_v;
            r_z <= (w_d_full == '0);
            r_n <= w_d_full[WIDTH-1];
        end
    end

    assign V = r_v;
    assign Z = r_z;
    assign N = r_n;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lookahead_subtractor_pipe.sv
// ============================================================================
// Module      : tb_lookahead_subtractor_pipe
// Description : Self-checking bench for lookahead_subtractor_pipe. A queue of
//               arithmetic results from accepted operands is compared with
//               every valid output; directed vectors pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lookahead_subtractor_pipe;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        bout;
`ifdef SUB_FLAGS_EN
    logic        V;
    logic        Z;
    logic        N;
`endif

    lookahead_subtractor_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .bout      (bout)
`ifdef SUB_FLAGS_EN
        ,
        .V         (V),
        .Z         (Z),
        .N         (N)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_in  = 0;
    int   n_out = 0;

    // Reference arithmetic: plain wide unsigned and signed integer math
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        exp_t        e;
        logic [16:0] diff;
        int          r;
        diff = {1'b0, a} - {1'b0, b} - {16'b0, bi};
        r    = int'($signed(a)) - int'($signed(b)) - int'(bi);
        e.d  = diff[15:0];
        e.bo = diff[16];
        e.z  = (diff[15:0] == 16'h0000);
        e.n  = diff[15];
        e.v  = (r < -32768) || (r > 32767);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: every valid output against the oldest pending result
    always @(negedge Clk) begin
        if (!Reset) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL stale_result: got out_valid=1 D=0x%0h, required no pending result", D);
                end else begin
                    check("model_D", 32'(D), 32'(q[0].d));
                    check("model_bout", 32'(bout), 32'(q[0].bo));
`ifdef SUB_FLAGS_EN
                    check("model_V", 32'(V), 32'(q[0].v));
                    check("model_Z", 32'(Z), 32'(q[0].z));
                    check("model_N", 32'(N), 32'(q[0].n));
`endif
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(A, B, bin));
                n_in++;
            end
        end
    end

    task automatic sync();
        @(posedge Clk);
        #1;
    endtask

    // Present one operation and hold it until accepted; returns just after
    // the accepting edge so calls can be chained back-to-back.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int t;
        A        = a;
        B        = b;
        bin      = bi;
        in_valid = 1'b1;
        t        = 0;
        while (1) begin
            @(negedge Clk);
            if (in_ready) break;
            t++;
            if (t > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required acceptance", t);
                break;
            end
        end
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the next valid result and compare with literal expectations
    task automatic expect_next(input string name, input logic [15:0] ed, input logic eb);
        int t;
        t = 0;
        do begin
            @(negedge Clk);
            t++;
        end while (!out_valid && t < 20);
        check({name, "_latency"}, 32'(t), 32'd2);
        check({name, "_D"}, 32'(D), 32'(ed));
        check({name, "_bout"}, 32'(bout), 32'(eb));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_in;
        int base_out;
        Reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = 16'h0000;
        B         = 16'h0000;
        bin       = 1'b0;

        // Reset state
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_D", 32'(D), 32'd0);
        check("reset_bout", 32'(bout), 32'd0);
        sync();
        Reset = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors with literal results
        sync(); send(16'h1234, 16'h0234, 1'b0); expect_next("basic",      16'h1000, 1'b0);
        sync(); send(16'h0000, 16'h0001, 1'b0); expect_next("wrap",       16'hFFFF, 1'b1);
        sync(); send(16'h8000, 16'h7FFF, 1'b1); expect_next("bin_zero",   16'h0000, 1'b0);
        sync(); send(16'h0100, 16'h0001, 1'b0); expect_next("cross_half", 16'h00FF, 1'b0);
        sync(); send(16'h0000, 16'h0000, 1'b1); expect_next("bin_only",   16'hFFFF, 1'b1);
        sync(); send(16'hFFFF, 16'hFFFF, 1'b1); expect_next("all_ones",   16'hFFFF, 1'b1);
        sync(); send(16'hABCD, 16'h1234, 1'b1); expect_next("mixed",      16'h9998, 1'b0);

`ifdef SUB_FLAGS_EN
        sync(); send(16'h8000, 16'h0001, 1'b0); expect_next("ovf", 16'h7FFF, 1'b0);
        check("ovf_V", 32'(V), 32'd1);
        check("ovf_N", 32'(N), 32'd0);
        check("ovf_Z", 32'(Z), 32'd0);
        sync(); send(16'h5555, 16'h5555, 1'b0); expect_next("eq", 16'h0000, 1'b0);
        check("eq_Z", 32'(Z), 32'd1);
        check("eq_V", 32'(V), 32'd0);
        check("eq_N", 32'(N), 32'd0);
`endif

        // Back-to-back streaming at full rate
        sync();
        base_out = n_out;
        send(16'h0010, 16'h0003, 1'b0);
        send(16'h7FFF, 16'h8000, 1'b0);
        send(16'h00FF, 16'h0100, 1'b1);
        send(16'hF0F0, 16'h0F0F, 1'b0);
        send(16'h1357, 16'h2468, 1'b1);
        repeat (4) @(negedge Clk);
        check("stream_delivered", 32'(n_out - base_out), 32'd5);

        // Back-pressure: only two operations fit while the output is stalled
        sync();
        out_ready = 1'b0;
        base_in   = n_in;
        base_out  = n_out;
        fork
            begin
                send(16'h4000, 16'h0001, 1'b0);
                send(16'h0001, 16'h4000, 1'b0);
                send(16'h0F00, 16'h00F0, 1'b1);
                send(16'hFFFF, 16'h0000, 1'b0);
            end
        join_none
        repeat (6) @(negedge Clk);
        check("bp_accepted", 32'(n_in - base_in), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_hold_D", 32'(D), 32'h3FFF);
        check("bp_hold_bout", 32'(bout), 32'd0);
        sync();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("bp_drain_valid", 32'(out_valid), 32'd1);
        end
        @(negedge Clk);
        check("bp_delivered", 32'(n_out - base_out), 32'd4);
        check("bp_queue_empty", 32'(q.size()), 32'd0);

        // Reset with both stages occupied
        sync();
        out_ready = 1'b0;
        send(16'h1111, 16'h0001, 1'b0);
        send(16'h2222, 16'h0002, 1'b0);
        @(negedge Clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_D", 32'(D), 32'd0);
        check("async_rst_bout", 32'(bout), 32'd0);
        q.delete();
        @(posedge Clk);
        sync();
        Reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        sync(); send(16'h0005, 16'h0003, 1'b0); expect_next("post_rst_op", 16'h0002, 1'b0);

        repeat (3) @(negedge Clk);
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
